button_event_arbiter: RTL and testbench
=======================================

Name: button_event_arbiter

Overview:
- Sits downstream of the per-button debouncers (one per pushbutton). Takes their debounced levels and turns them into discrete press / release / auto-repeat events.
- Serialises events from all buttons onto one valid/ready event channel, using round-robin arbitration.
- Feeds the lab control FSMs, so they consume one button event at a time instead of polling raw levels.

Parameters:
- N_BTN, 4, number of debounced button inputs (2..8)
- HOLD_TICKS, 5000, clk cycles a button must stay pressed before the first repeat (500 ms at 10 kHz)
- REPEAT_TICKS, 2000, clk cycles between subsequent repeats (200 ms at 10 kHz)
- CNT_W, 16, hold/repeat timer width; must hold max(HOLD_TICKS, REPEAT_TICKS)-1

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- btn_state  in  N_BTN  debounced levels, 1 = pressed, already synchronous to clk
- repeat_en  in  N_BTN  per-button auto-repeat enable, static or quasi-static
- evt_valid  out  1  event offered
- evt_ready  in  1  consumer accepts event
- evt_id  out  $clog2(N_BTN)  index of the button that generated the event
- evt_type  out  2  event type: 00 press, 01 release, 10 repeat, 11 unused
- pending  out  N_BTN  bit i = button i has at least one undelivered event

Behaviour:
- Reset (async, reset_n low):
  - Outputs: evt_valid=0, evt_id=0, evt_type=00, pending=0.
  - Internal: btn_prev=0, all pending flags=0, timer idle, rr pointer=N_BTN-1, FSM in IDLE.
  - A button held through reset therefore yields a press event after reset deasserts.
- Edge detect:
  - btn_prev registers btn_state every cycle.
  - Rise (state=1, prev=0) sets press_pend[i].
  - Fall (state=0, prev=1) sets release_pend[i] and clears repeat_pend[i].
  - Pending flags are single bits: repeated identical events before delivery coalesce into one, with no overflow indication.
- Hold timer: one shared timer owned by a tracked button index trk.
  - Load: on a rise of any button i with repeat_en[i]=1, trk<=i, timer<=0, phase<=HOLD.
  - If several such buttons rise in the same cycle, the lowest index wins trk.
  - While btn_state[trk]=1 and repeat_en[trk]=1, the timer increments each cycle.
  - In phase HOLD, at timer==HOLD_TICKS-1: set repeat_pend[trk], timer<=0, phase<=REPEAT.
  - In phase REPEAT, at timer==REPEAT_TICKS-1: set repeat_pend[trk], timer<=0.
  - First repeat flag is set HOLD_TICKS cycles after the rise is detected; subsequent flags every REPEAT_TICKS cycles.
  - Fall of trk, or repeat_en[trk] going 0, makes the timer idle.
- Arbiter FSM, states IDLE and OFFER:
  - IDLE: if any pending flag is set, pick the first button with pending[i]=1, scanning (rr+1) mod N_BTN upward with wrap.
  - Type priority within the chosen button: press > repeat > release. This guarantees press is delivered before release.
  - In the same cycle: register evt_id/evt_type, clear the chosen flag, rr<=i, go to OFFER.
  - OFFER: evt_valid=1; evt_id and evt_type held stable until evt_valid && evt_ready. On that handshake edge, return to IDLE with evt_valid=0.
  - evt_valid is low for at least 1 cycle between events, so peak throughput is one event per 2 cycles.
  - evt_valid is never withdrawn without a handshake.
- Simultaneous events:
  - An edge that sets a flag in the same cycle the arbiter clears that same flag: the set wins, so a new event is never lost.
  - Flags keep accumulating during OFFER, including for the button currently being offered.
- pending[i] = press_pend[i] | release_pend[i] | repeat_pend[i], registered.
- Reset mid-OFFER: the event in flight and all pending events are discarded. evt_valid drops asynchronously.

Test Plan:
1. N_BTN=4, evt_ready=1. Pulse btn_state[2] high for 10 cycles → press(id 2) with evt_valid 2 cycles after the rise, then release(id 2). Exactly 2 events.
2. btn_state[0], [1] and [3] rise in the same cycle, evt_ready=1 → press events in order id 0, 1, 3 (rr starts at 3). Raise 0 and 3 again → order 0, 3.
3. Backpressure: evt_ready=0 for 20 cycles while button 1 presses and releases → evt_id/evt_type held stable throughout. On evt_ready=1: press(1) then release(1), with no duplicates.
4. HOLD_TICKS=5, REPEAT_TICKS=3, repeat_en[0]=1. Hold button 0 for 14 cycles after detection → press, then repeats whose flags set at cycles 5, 8, 11 and 14, then release.
5. Same settings, release button 0 at cycle 4 → no repeat. Also with repeat_en[0]=0 held 100 cycles → only press and release.
6. Assert reset_n low during OFFER with 3 pending flags → evt_valid=0 immediately. After release of reset, no stale events; a held button yields one press.

Source files
------------

// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into press/release/auto-repeat events and
// serialises them round-robin onto a single valid/ready event channel.
module button_event_arbiter #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned HOLD_TICKS   = 5000,
    parameter int unsigned REPEAT_TICKS = 2000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_BTN-1:0]           btn_state_i,
    input  logic [N_BTN-1:0]           repeat_en_i,
    output logic                       evt_valid_o,
    input  logic                       evt_ready_i,
    output logic [$clog2(N_BTN)-1:0]   evt_id_o,
    output logic [1:0]                 evt_type_o,
    output logic [N_BTN-1:0]           pending_o
);

    localparam int unsigned ID_W = $clog2(N_BTN);

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;

    typedef enum logic { ST_IDLE, ST_OFFER } state_e;
    typedef enum logic { PH_HOLD, PH_REPEAT } phase_e;

    state_e              state_q;
    phase_e              phase_q, phase_d;
    logic [N_BTN-1:0]    btn_prev_q;
    logic [N_BTN-1:0]    press_q, press_d;
    logic [N_BTN-1:0]    release_q, release_d;
    logic [N_BTN-1:0]    repeat_q, repeat_d;
    logic [N_BTN-1:0]    pending_q;
    logic [ID_W-1:0]     rr_q;
    logic [ID_W-1:0]     trk_q, trk_d;
    logic [CNT_W-1:0]    tmr_q, tmr_d;
    logic                tmr_active_q, tmr_active_d;
    logic                evt_valid_q;
    logic [ID_W-1:0]     evt_id_q;
    logic [1:0]          evt_type_q;

    logic [N_BTN-1:0]    rise, fall, rep_rise, rep_set, pend_all;
    logic [N_BTN-1:0]    clr_press, clr_release, clr_repeat;
    logic                found;
    logic [ID_W-1:0]     pick;
    logic [1:0]          pick_type;
    int unsigned         idx;

    assign evt_valid_o = evt_valid_q;
    assign evt_id_o    = evt_id_q;
    assign evt_type_o  = evt_type_q;
    assign pending_o   = pending_q;

    // Edge detection and the shared hold/repeat timer.
    always_comb begin
        rise         = btn_state_i & ~btn_prev_q;
        fall         = ~btn_state_i & btn_prev_q;
        rep_rise     = rise & repeat_en_i;
        rep_set      = '0;
        trk_d        = trk_q;
        tmr_d        = tmr_q;
        phase_d      = phase_q;
        tmr_active_d = tmr_active_q;
        if (|rep_rise) begin
            tmr_active_d = 1'b1;
            tmr_d        = '0;
            phase_d      = PH_HOLD;
            for (int i = N_BTN - 1; i >= 0; i--) begin
                if (rep_rise[i]) trk_d = ID_W'(i);
            end
        end else if (tmr_active_q && btn_state_i[trk_q] && repeat_en_i[trk_q]) begin
            if (phase_q == PH_HOLD && tmr_q == CNT_W'(HOLD_TICKS - 1)) begin
                rep_set[trk_q] = 1'b1;
                tmr_d          = '0;
                phase_d        = PH_REPEAT;
            end else if (phase_q == PH_REPEAT && tmr_q == CNT_W'(REPEAT_TICKS - 1)) begin
                rep_set[trk_q] = 1'b1;
                tmr_d          = '0;
            end else begin
                tmr_d = tmr_q + CNT_W'(1);
            end
        end else begin
            tmr_active_d = 1'b0;
        end
    end

    // Round-robin pick starting after the last served button; a new set beats a clear.
    always_comb begin
        pend_all    = press_q | release_q | repeat_q;
        found       = 1'b0;
        pick        = '0;
        pick_type   = EVT_PRESS;
        idx         = 0;
        clr_press   = '0;
        clr_release = '0;
        clr_repeat  = '0;
        for (int unsigned k = 1; k <= N_BTN; k++) begin
            idx = (32'(rr_q) + k) % N_BTN;
            if (!found && pend_all[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
        if (press_q[pick])       pick_type = EVT_PRESS;
        else if (repeat_q[pick]) pick_type = EVT_REPEAT;
        else                     pick_type = EVT_RELEASE;
        if (state_q == ST_IDLE && found) begin
            case (pick_type)
                EVT_PRESS:  clr_press[pick]   = 1'b1;
                EVT_REPEAT: clr_repeat[pick]  = 1'b1;
                default:    clr_release[pick] = 1'b1;
            endcase
        end
        press_d   = (press_q & ~clr_press) | rise;
        release_d = (release_q & ~clr_release) | fall;
        repeat_d  = ((repeat_q & ~clr_repeat) | rep_set) & ~fall;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_HOLD;
            btn_prev_q   <= '0;
            press_q      <= '0;
            release_q    <= '0;
            repeat_q     <= '0;
            pending_q    <= '0;
            rr_q         <= ID_W'(N_BTN - 1);
            trk_q        <= '0;
            tmr_q        <= '0;
            tmr_active_q <= 1'b0;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            evt_type_q   <= EVT_PRESS;
        end else begin
            btn_prev_q   <= btn_state_i;
            press_q      <= press_d;
            release_q    <= release_d;
            repeat_q     <= repeat_d;
            pending_q    <= press_d | release_d | repeat_d;
            trk_q        <= trk_d;
            tmr_q        <= tmr_d;
            phase_q      <= phase_d;
            tmr_active_q <= tmr_active_d;
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        evt_id_q    <= pick;
                        evt_type_q  <= pick_type;
                        rr_q        <= pick;
                        evt_valid_q <= 1'b1;
                        state_q     <= ST_OFFER;
                    end
                end
                default: begin
                    if (evt_ready_i) begin
                        evt_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: expected events are queued as
// stimulus is applied and compared at each valid/ready handshake.
module tb_button_event_arbiter;

    localparam int unsigned N_BTN  = 4;
    localparam int unsigned HOLD   = 5;
    localparam int unsigned REP    = 3;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned T_PRESS = 0;
    localparam int unsigned T_REL   = 1;
    localparam int unsigned T_REP   = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N_BTN-1:0]  btn_state = '0;
    logic [N_BTN-1:0]  repeat_en = '0;
    logic              evt_ready = 1'b0;
    logic              evt_valid;
    logic [ID_W-1:0]   evt_id;
    logic [1:0]        evt_type;
    logic [N_BTN-1:0]  pending;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned sb[$];

    always #5 clk = ~clk;

    button_event_arbiter #(
        .N_BTN(N_BTN), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_state_i(btn_state),
        .repeat_en_i(repeat_en),
        .evt_valid_o(evt_valid),
        .evt_ready_i(evt_ready),
        .evt_id_o(evt_id),
        .evt_type_o(evt_type),
        .pending_o(pending)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int unsigned ev(input int unsigned id, input int unsigned t);
        return id * 4 + t;
    endfunction

    // Handshake monitor plus hold-stability check under backpressure.
    logic            prev_hold = 1'b0;
    logic [ID_W-1:0] prev_id   = '0;
    logic [1:0]      prev_type = '0;
    int unsigned     exp_ev;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("valid_held", evt_valid, 1);
                chk("id_stable", evt_id, prev_id);
                chk("type_stable", evt_type, prev_type);
            end
            if (evt_valid && evt_ready) begin
                chk("event_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_ev = sb.pop_front();
                    chk("event(id*4+type)", ev(evt_id, evt_type), exp_ev);
                end
            end
            prev_hold = evt_valid && !evt_ready;
            prev_id   = evt_id;
            prev_type = evt_type;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        btn_state = '0;
        repeat_en = '0;
        evt_ready = 1'b1;
        sb.delete();
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic drain(input string tag);
        int unsigned budget = 300;
        while (sb.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        chk({tag, "_drained"}, sb.size(), 0);
        tick(4);
        @(negedge clk);
        chk({tag, "_pending_clear"}, pending, 0);
        chk({tag, "_valid_idle"}, evt_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #2;
        @(negedge clk);
        chk("rst_valid", evt_valid, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_type", evt_type, 0);
        chk("rst_pending", pending, 0);
        tick(1);

        // single press/release with latency check
        do_reset();
        btn_state[2] = 1'b1;
        sb.push_back(ev(2, T_PRESS));
        @(negedge clk); chk("lat_c0_valid", evt_valid, 0);
        @(negedge clk); chk("lat_c1_valid", evt_valid, 0);
        @(negedge clk); chk("lat_c2_valid", evt_valid, 1);
        @(posedge clk); #1;
        tick(7);
        btn_state[2] = 1'b0;
        sb.push_back(ev(2, T_REL));
        drain("t1");

        // simultaneous rises, round-robin order
        do_reset();
        btn_state = 4'b1011;
        sb.push_back(ev(0, T_PRESS)); sb.push_back(ev(1, T_PRESS)); sb.push_back(ev(3, T_PRESS));
        drain("t2a");
        btn_state = 4'b0000;
        sb.push_back(ev(0, T_REL)); sb.push_back(ev(1, T_REL)); sb.push_back(ev(3, T_REL));
        drain("t2b");
        btn_state = 4'b1001;
        sb.push_back(ev(0, T_PRESS)); sb.push_back(ev(3, T_PRESS));
        drain("t2c");
        btn_state = 4'b0000;
        sb.push_back(ev(0, T_REL)); sb.push_back(ev(3, T_REL));
        drain("t2d");

        // backpressure
        do_reset();
        evt_ready = 1'b0;
        btn_state[1] = 1'b1;
        sb.push_back(ev(1, T_PRESS));
        tick(8);
        btn_state[1] = 1'b0;
        sb.push_back(ev(1, T_REL));
        tick(12);
        @(negedge clk);
        chk("bp_valid", evt_valid, 1);
        chk("bp_id", evt_id, 1);
        chk("bp_type", evt_type, T_PRESS);
        chk("bp_pending", pending, 4'b0010);
        @(posedge clk); #1;
        evt_ready = 1'b1;
        drain("t3");

        // auto-repeat: held 15 sampled cycles -> 4 repeats
        do_reset();
        repeat_en[0] = 1'b1;
        btn_state[0] = 1'b1;
        sb.push_back(ev(0, T_PRESS));
        for (int i = 0; i < 4; i++) sb.push_back(ev(0, T_REP));
        tick(15);
        btn_state[0] = 1'b0;
        sb.push_back(ev(0, T_REL));
        drain("t4");

        // short hold: no repeat
        do_reset();
        repeat_en[0] = 1'b1;
        btn_state[0] = 1'b1;
        sb.push_back(ev(0, T_PRESS));
        tick(4);
        btn_state[0] = 1'b0;
        sb.push_back(ev(0, T_REL));
        drain("t5a");

        // repeat disabled: long hold, no repeat
        do_reset();
        btn_state[0] = 1'b1;
        sb.push_back(ev(0, T_PRESS));
        tick(100);
        btn_state[0] = 1'b0;
        sb.push_back(ev(0, T_REL));
        drain("t5b");

        // reset during OFFER with three pending flags
        do_reset();
        evt_ready = 1'b0;
        btn_state = 4'b1111;
        tick(3);
        @(negedge clk);
        chk("t6_valid", evt_valid, 1);
        chk("t6_pending_cnt", $countones(pending), 3);
        chk("t6_offered_cleared", pending[evt_id], 0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", evt_valid, 0);
        chk("t6_async_pending", pending, 0);
        btn_state = 4'b0001;
        tick(3);
        sb.delete();
        sb.push_back(ev(0, T_PRESS));
        reset_n   = 1'b1;
        evt_ready = 1'b1;
        drain("t6");
        btn_state = '0;
        sb.push_back(ev(0, T_REL));
        drain("t6b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
